// File: rtl/axis_out_frame_mon.sv
// AXI-Stream frame monitor: counts a fixed-size frame through a 2-entry skid buffer,
// regenerates end-of-row markers from its own column count and flags upstream tlast errors.
module axis_out_frame_mon #(
  parameter int AXISOUT_DATA_WIDTH = 32,
  parameter int DST_IMG_WIDTH      = 4096,
  parameter int DST_IMG_HEIGHT     = 2160,
  parameter int PIX_PER_BEAT       = 4,
  localparam int ROW_W             = $clog2(DST_IMG_HEIGHT + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_start,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [AXISOUT_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [AXISOUT_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [AXISOUT_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            err_tlast,
  input  logic                            err_clr,
  output logic [ROW_W-1:0]                row_cnt
);

  localparam int BEATS_PER_ROW = DST_IMG_WIDTH / PIX_PER_BEAT;
  localparam int TOTAL_BEATS   = DST_IMG_HEIGHT * BEATS_PER_ROW;
  localparam int CNT_W         = $clog2(TOTAL_BEATS + 1);
  localparam int COL_W         = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic [CNT_W-1:0]              in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]              out_cnt_q, out_cnt_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [1:0]                    fill_q, fill_d;
  logic                          tready_q, tready_d;
  logic                          err_q, err_d;
  // Entry 0 is the head and drives the output port directly; entry 1 is the skid slot.
  logic [AXISOUT_DATA_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic                          head_last_q, head_last_d, tail_last_q, tail_last_d;

  logic       push, pop, in_last;
  logic [1:0] wr_pos;

  assign push    = s_axis_tvalid & tready_q;
  assign pop     = (fill_q != 2'd0) & m_axis_tready;
  assign in_last = (col_q == COL_W'(BEATS_PER_ROW - 1));
  assign wr_pos  = fill_q - {1'b0, pop};

  // NOTE: every variable gets a default at the top of always_comb so that no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    err_d       = err_q & ~err_clr;
    fill_d      = fill_q + {1'b0, push} - {1'b0, pop};

    if (pop) begin
      head_data_d = tail_data_q;
      head_last_d = tail_last_q;
      out_cnt_d   = out_cnt_q + 1'b1;
      if (head_last_q && (row_q != ROW_W'(DST_IMG_HEIGHT))) row_d = row_q + 1'b1;
    end

    if (push) begin
      if (wr_pos == 2'd0) begin
        head_data_d = s_axis_tdata;
        head_last_d = in_last;
      end else begin
        tail_data_d = s_axis_tdata;
        tail_last_d = in_last;
      end
      col_d    = in_last ? '0 : col_q + 1'b1;
      in_cnt_d = in_cnt_q + 1'b1;
      // A mismatch sets the flag even when err_clr is asserted in the same cycle.
      if (s_axis_tlast != in_last) err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d   = ST_RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          col_d     = '0;
          row_d     = '0;
        end
      end
      ST_RUN: begin
        if (push && (in_cnt_q == CNT_W'(TOTAL_BEATS - 1))) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if ((fill_d == 2'd0) && (out_cnt_d == CNT_W'(TOTAL_BEATS))) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered ready looks at next-cycle occupancy, so m_axis_tready never reaches s_axis_tready combinationally.
    tready_d = (state_d == ST_RUN) && (fill_d < 2'd2);
  end

  // NOTE: the two buffer entries are reset along with the control state because the
  // head entry drives m_axis_tdata, which must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      fill_q      <= 2'd0;
      tready_q    <= 1'b0;
      err_q       <= 1'b0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // the same pre-edge values regardless of statement order.
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fill_q      <= fill_d;
      tready_q    <= tready_d;
      err_q       <= err_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = (fill_q != 2'd0);
  assign m_axis_tdata  = head_data_q;
  assign m_axis_tlast  = head_last_q & (fill_q != 2'd0);
  assign m_axis_tkeep  = '1;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = (state_q == ST_DONE);
  assign err_tlast     = err_q;
  assign row_cnt       = row_q;

endmodule

// File: tb/tb_axis_out_frame_mon.sv
// Scoreboard bench for axis_out_frame_mon with a 2-row, 4-beat-per-row frame.
module tb_axis_out_frame_mon;

  localparam int DW  = 32;
  localparam int BPR = 4;
  localparam int KW  = DW / 8;
  localparam int RW  = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [KW-1:0] m_tkeep;
  logic          busy, frame_done, err_tlast;
  logic          err_clr = 1'b0;
  logic [RW-1:0] row_cnt;

  axis_out_frame_mon #(
    .AXISOUT_DATA_WIDTH(DW),
    .DST_IMG_WIDTH     (16),
    .DST_IMG_HEIGHT    (2),
    .PIX_PER_BEAT      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tlast (m_tlast),
    .m_axis_tkeep (m_tkeep),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_tlast    (err_tlast),
    .err_clr      (err_clr),
    .row_cnt      (row_cnt)
  );

  always #5 clk = ~clk;

  beat_t         exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            mode = 0;  // 0: ready high, 1: ready toggles, 2: ready low
  int            cyc = 0;
  int            done_cnt = 0;
  int            out_cnt = 0;
  int            last_hs_cyc = 0;
  int            occ = 0;
  int            col_m = 0;
  logic          err_m = 1'b0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: samples on the falling edge, i.e. the handshakes that the next rising edge completes.
  always @(negedge clk) begin
    logic  in_hs, out_hs, set;
    beat_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      occ     = 0;
      col_m   = 0;
      err_m   = 1'b0;
      stall_q = 1'b0;
    end else begin
      in_hs  = s_tvalid & s_tready;
      out_hs = m_tvalid & m_tready;
      if (occ == 2) check("tready_when_full", 64'(s_tready), 64'(0));
      if (stall_q) begin
        check("valid_held", 64'(m_tvalid), 64'(1));
        check("beat_held", 64'({m_tdata, m_tlast}), 64'({stall_data, stall_last}));
      end
      check("err_tlast", 64'(err_tlast), 64'(err_m));
      if (frame_done) begin
        done_cnt++;
        check("done_latency", 64'(cyc - last_hs_cyc), 64'(1));
      end
      if (out_hs) begin
        check("out_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", 64'(m_tdata), 64'(e.data));
          check("out_last", 64'(m_tlast), 64'(e.last));
        end
        out_cnt++;
        last_hs_cyc = cyc;
      end
      stall_q    = m_tvalid & ~m_tready;
      stall_data = m_tdata;
      stall_last = m_tlast;
      set   = in_hs && (s_tlast != (col_m == BPR - 1));
      err_m = set | (err_m & ~err_clr);
      if (in_hs) col_m = (col_m == BPR - 1) ? 0 : col_m + 1;
      occ = occ + int'(in_hs) - int'(out_hs);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("busy_after_arm", 64'(busy), 64'(1));
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic exp_l);
    bit got = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (s_tready) begin
        exp_q.push_back({d, exp_l});
        got = 1;
      end
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!got) check("input_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_beats(input logic [DW-1:0] base, input int first, input int n,
                            input int err_beat, input int fs_beat);
    logic el;
    for (int i = first; i < first + n; i++) begin
      el = ((i % BPR) == BPR - 1);
      if (i == fs_beat) frame_start = 1'b1;
      send_beat(base + DW'(i), el ^ (i == err_beat), el);
      frame_start = 1'b0;
    end
  endtask

  task automatic wait_done(input int prev_done, input int prev_out);
    for (int k = 0; k < 500 && done_cnt == prev_done; k++) tick();
    repeat (3) tick();
    check("done_count", 64'(done_cnt), 64'(prev_done + 1));
    check("out_count", 64'(out_cnt), 64'(prev_out + 8));
    check("row_cnt", 64'(row_cnt), 64'(2));
    check("busy_idle", 64'(busy), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tdata", 64'(m_tdata), 64'(0));
    check("rst_m_tlast", 64'(m_tlast), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_err", 64'(err_tlast), 64'(0));
    check("rst_row_cnt", 64'(row_cnt), 64'(0));
  endtask

  initial begin
    int d0, o0;
    repeat (3) tick();
    check_reset_outputs();
    check("tkeep", 64'(m_tkeep), 64'(4'hF));
    rst = 1'b0;
    tick();

    // Plain frame, downstream always ready.
    mode = 0;
    tick();
    d0 = done_cnt; o0 = out_cnt;
    arm();
    check("tready_first_run", 64'(s_tready), 64'(1));
    send_beats(32'h100, 0, 8, -1, -1);
    wait_done(d0, o0);

    // Downstream ready toggling every cycle.
    mode = 1;
    d0 = done_cnt; o0 = out_cnt;
    arm();
    send_beats(32'h200, 0, 8, -1, -1);
    wait_done(d0, o0);

    // Wrong upstream tlast on beat 1, then clear the flag.
    mode = 0;
    tick();
    d0 = done_cnt; o0 = out_cnt;
    arm();
    send_beats(32'h300, 0, 8, 1, -1);
    wait_done(d0, o0);
    check("err_set", 64'(err_tlast), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 64'(err_tlast), 64'(0));

    // Reset mid-frame with two beats held in the buffer.
    arm();
    send_beats(32'h400, 0, 4, -1, -1);
    repeat (3) tick();
    check("row_cnt_mid", 64'(row_cnt), 64'(1));
    mode = 2;
    repeat (2) tick();
    o0 = out_cnt;
    send_beats(32'h400, 4, 2, -1, -1);
    repeat (2) tick();
    check("held_no_output", 64'(out_cnt), 64'(o0));
    check("held_valid", 64'(m_tvalid), 64'(1));
    rst = 1'b1;
    tick();
    check_reset_outputs();
    rst = 1'b0;
    mode = 0;
    repeat (2) tick();
    check("no_output_after_rst", 64'(out_cnt), 64'(o0));
    d0 = done_cnt; o0 = out_cnt;
    arm();
    send_beats(32'h500, 0, 8, -1, -1);
    wait_done(d0, o0);

    // frame_start pulsed during RUN is ignored.
    d0 = done_cnt; o0 = out_cnt;
    arm();
    send_beats(32'h600, 0, 8, -1, 2);
    wait_done(d0, o0);
    repeat (10) tick();
    check("single_done", 64'(done_cnt), 64'(d0 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_out_frame_mon.md
AXIS_OUT_FRAME_MON -- requirements
Module: axis_out_frame_mon

Interface
REQ-001 SHALL have parameter AXISOUT_DATA_WIDTH, default 32, beat data width in bits.
REQ-002 SHALL have parameter DST_IMG_WIDTH, default 4096, destination pixels per row.
REQ-003 SHALL have parameter DST_IMG_HEIGHT, default 2160, destination rows per frame.
REQ-004 SHALL have parameter PIX_PER_BEAT, default 4, pixels per beat; BEATS_PER_ROW = DST_IMG_WIDTH/PIX_PER_BEAT.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all logic on its rising edge
- rst  in  1  reset; synchronous, active-high
- frame_start  in  1  one-cycle pulse arming a new frame
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tready  out  1  upstream ready
- s_axis_tdata  in  AXISOUT_DATA_WIDTH  upstream data
- s_axis_tlast  in  1  upstream end-of-row marker
- m_axis_tvalid  out  1  downstream valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  AXISOUT_DATA_WIDTH  downstream data
- m_axis_tlast  out  1  regenerated end-of-row marker
- m_axis_tkeep  out  AXISOUT_DATA_WIDTH/8  byte keep, tied all-ones
- busy  out  1  high from arming to frame completion
- frame_done  out  1  one-cycle completion pulse
- err_tlast  out  1  sticky tlast-mismatch flag
- err_clr  in  1  clears err_tlast
- row_cnt  out  clog2(DST_IMG_HEIGHT+1)  rows fully sent downstream

Function
REQ-006 SHALL implement FSM IDLE, RUN, FLUSH, DONE.
REQ-007 IDLE: s_axis_tready=0; frame_start -> RUN next cycle; input/output beat counters and row_cnt cleared on that transition.
REQ-008 RUN: accept beats per AXI-Stream handshake (tvalid & tready); after the handshake of input beat DST_IMG_HEIGHT*BEATS_PER_ROW -> FLUSH.
REQ-009 FLUSH: s_axis_tready=0; once buffer empty and final output handshake done -> DONE.
REQ-010 DONE: frame_done=1 for exactly one cycle -> IDLE.
REQ-011 busy SHALL be 1 in RUN, FLUSH, DONE; 0 in IDLE.
REQ-012 frame_start outside IDLE SHALL be ignored.
REQ-013 SHALL buffer through a 2-entry skid buffer: s_axis_tready registered, high in RUN whenever fewer than 2 entries occupied; no combinational path from m_axis_tready to s_axis_tready.
REQ-014 Latency input handshake to m_axis_tvalid SHALL be exactly 1 cycle when buffer empty; sustained throughput 1 beat/cycle with m_axis_tready held high.
REQ-015 m_axis_tvalid, once high, SHALL not drop and m_axis_tdata/m_axis_tlast SHALL stay stable until handshake.
REQ-016 m_axis_tlast SHALL be derived from the input column counter, not s_axis_tlast: 1 on beat index BEATS_PER_ROW-1 of each row; column counter wraps to 0 after it.
REQ-017 On each input handshake, s_axis_tlast != (column == BEATS_PER_ROW-1) SHALL set err_tlast next cycle; beat still forwarded, counting unaffected.
REQ-018 err_clr SHALL clear err_tlast next cycle; simultaneous set and clear -> set wins.
REQ-019 row_cnt SHALL increment on each output handshake with m_axis_tlast=1; saturates at DST_IMG_HEIGHT.
REQ-020 Beat counters SHALL be wide enough for DST_IMG_HEIGHT*BEATS_PER_ROW without overflow.
REQ-021 m_axis_tkeep SHALL be all-ones constantly.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE, empty buffer, counters 0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, frame_done=0, err_tlast=0, row_cnt=0.
REQ-023 rst mid-frame SHALL discard buffered beats without emitting them; a subsequent frame_start starts a clean frame.

Verification
REQ-024 Small params (WIDTH=16, HEIGHT=2, PIX=4); frame_start, 8 beats with correct tlast, m_axis_tready=1 -> 8 outputs, tlast on beats 3 and 7, row_cnt=2, frame_done pulse one cycle after last output handshake.
REQ-025 Same frame, m_axis_tready toggled 1/0 each cycle -> no data lost or duplicated, s_axis_tready never high with 2 entries held, output order intact.
REQ-026 s_axis_tlast=1 on beat 1 -> err_tlast=1 next cycle, m_axis_tlast still only on beats 3 and 7; err_clr -> err_tlast=0.
REQ-027 rst asserted after beat 5 with m_axis_tready=0 -> all outputs at reset values next cycle; new frame_start then delivers 8 fresh beats.
REQ-028 frame_start pulsed during RUN -> counters unaffected, exactly one frame_done.
